// File: rtl/stack_cmd_master.sv
// Command-driven initiator for a we/delta/wd/rd RAM stack: turns host PEEK/PUSH/POP/REPLACE
// commands into stack cycles, tracks depth, and answers over a valid/ready response channel.
module stack_cmd_master #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [AW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic [WIDTH-1:0] stk_rd
);

  localparam logic [1:0] OP_PEEK    = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;

  localparam logic [AW-1:0] DEPTH_MAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [1:0]       r_op,        w_op_nxt;
  logic [WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic [WIDTH-1:0] r_rdata,     w_rdata_nxt;
  logic             r_err,       w_err_nxt;
  logic [AW-1:0]    r_depth,     w_depth_nxt;
  logic             r_empty,     w_empty_nxt;
  logic             r_full,      w_full_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0] r_rsp_data,  w_rsp_data_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;
  logic             r_stk_we,    w_stk_we_nxt;
  logic [1:0]       r_stk_delta, w_stk_delta_nxt;
  logic [WIDTH-1:0] r_stk_wd,    w_stk_wd_nxt;

  logic w_accept;
  logic w_cmd_err;

  assign w_accept  = cmd_valid & r_cmd_ready;
  // PUSH can only overflow; every other op needs something on the stack.
  assign w_cmd_err = (cmd_op == OP_PUSH) ? r_full : r_empty;

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_wdata_nxt     = r_wdata;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = r_err;
    w_depth_nxt     = r_depth;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_stk_we_nxt    = 1'b0;
    w_stk_delta_nxt = DELTA_HOLD;
    w_stk_wd_nxt    = r_stk_wd;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = S_ISSUE;
          w_op_nxt        = cmd_op;
          w_wdata_nxt     = cmd_data;
          w_rdata_nxt     = stk_rd;
          w_err_nxt       = w_cmd_err;
          w_cmd_ready_nxt = 1'b0;
          w_stk_wd_nxt    = cmd_data;
          if (!w_cmd_err) begin
            w_stk_we_nxt = (cmd_op == OP_PUSH) || (cmd_op == OP_REPLACE);
            case (cmd_op)
              OP_PUSH: w_stk_delta_nxt = DELTA_PUSH;
              OP_POP:  w_stk_delta_nxt = DELTA_POP;
              default: w_stk_delta_nxt = DELTA_HOLD;
            endcase
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_SETTLE;
        if (!r_err && r_op == OP_PUSH) w_depth_nxt = r_depth + AW'(1);
        if (!r_err && r_op == OP_POP)  w_depth_nxt = r_depth - AW'(1);
      end
      S_SETTLE: begin
        // Reads return the pre-op top sampled at acceptance; writes echo their data.
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = r_err;
        if (r_err)
          w_rsp_data_nxt = '0;
        else if (r_op == OP_PEEK || r_op == OP_POP)
          w_rsp_data_nxt = r_rdata;
        else
          w_rsp_data_nxt = r_wdata;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_empty_nxt = (w_depth_nxt == '0);
    w_full_nxt  = (w_depth_nxt == DEPTH_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_PEEK;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_depth     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_stk_we    <= 1'b0;
      r_stk_delta <= DELTA_HOLD;
      r_stk_wd    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_depth     <= w_depth_nxt;
      r_empty     <= w_empty_nxt;
      r_full      <= w_full_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_stk_we    <= w_stk_we_nxt;
      r_stk_delta <= w_stk_delta_nxt;
      r_stk_wd    <= w_stk_wd_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign depth     = r_depth;
  assign empty     = r_empty;
  assign full      = r_full;
  assign stk_we    = r_stk_we;
  assign stk_delta = r_stk_delta;
  assign stk_wd    = r_stk_wd;

endmodule

// File: tb/tb_stack_cmd_master.sv
// Bench for stack_cmd_master: directed vector table, reset-abort sequence, and random
// commands checked against a queue-based stack model.
module tb_stack_cmd_master;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CAP   = DEPTH - 1;

  localparam logic [1:0] PEEK = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] REPL = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [AW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             stk_we;
  logic [1:0]       stk_delta;
  logic [WIDTH-1:0] stk_wd;
  logic [WIDTH-1:0] stk_rd;

  stack_cmd_master #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .depth(depth), .empty(empty), .full(full),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd)
  );

  always #5 clk = ~clk;

  // Stack instance stand-in: registered pointer, top read straight out of the array.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_step;
  assign sp_step = {stk_delta[1], stk_delta};
  assign stk_rd  = mem[sp];

  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

  always @(posedge clk) begin
    if (rst) sp <= '0;
    else begin
      if (stk_we) mem[sp + sp_step] <= stk_wd;
      sp <= sp + sp_step;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [2:0]  exp_depth;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] op, input logic [15:0] d, input logic [15:0] ed,
                              input logic ee, input logic [2:0] edp, input int hold = 0);
    vec_t v;
    v.op = op; v.data = d; v.exp_data = ed; v.exp_err = ee; v.exp_depth = edp; v.hold = hold;
    vecs.push_back(v);
  endfunction

  // One full command transaction with cycle-exact checks of the stack op and response.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input logic [15:0] ed,
                        input logic ee, input logic [2:0] edp, input int hold, input string tag);
    logic        exp_we;
    logic [1:0]  exp_dl;
    logic [15:0] held;
    int          waited;
    exp_we = !ee && (op == PUSH || op == REPL);
    exp_dl = ee ? 2'b00 : (op == PUSH) ? 2'b01 : (op == POP) ? 2'b11 : 2'b00;
    @(negedge clk);
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk({tag, ".cmd_ready_timeout"}, 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 16'hDEAD;
    chk({tag, ".t1_we"},        32'(stk_we),    32'(exp_we));
    chk({tag, ".t1_delta"},     32'(stk_delta), 32'(exp_dl));
    if (exp_we) chk({tag, ".t1_wd"}, 32'(stk_wd), 32'(d));
    chk({tag, ".t1_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, ".t1_rsp_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".t2_we"},        32'(stk_we),    32'd0);
    chk({tag, ".t2_delta"},     32'(stk_delta), 32'd0);
    chk({tag, ".t2_depth"},     32'(depth),     32'(edp));
    chk({tag, ".t2_rsp_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".t3_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_data"},     32'(rsp_data),  32'(ed));
    chk({tag, ".rsp_err"},      32'(rsp_err),   32'(ee));
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"},     32'(rsp_valid), 32'd1);
      chk({tag, ".hold_data"},      32'(rsp_data),  32'(held));
      chk({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"},     32'(rsp_valid), 32'd0);
    chk({tag, ".done_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".done_empty"},     32'(empty),     32'(edp == 3'd0));
    chk({tag, ".done_full"},      32'(full),      32'(edp == 3'(CAP)));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, ".rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, ".depth"},     32'(depth),     32'd0);
    chk({tag, ".empty"},     32'(empty),     32'd1);
    chk({tag, ".full"},      32'(full),      32'd0);
    chk({tag, ".stk_we"},    32'(stk_we),    32'd0);
    chk({tag, ".stk_delta"}, 32'(stk_delta), 32'd0);
    chk({tag, ".stk_wd"},    32'(stk_wd),    32'd0);
  endtask

  initial begin
    logic [15:0] model [$];
    logic [1:0]  op;
    logic [15:0] d;
    logic [15:0] ed;
    logic        ee;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; rsp_ready = 1'b0;

    // Directed vectors: expected values worked out by hand from the command rules.
    add(PUSH, 16'h1234, 16'h1234, 1'b0, 3'd1);
    add(POP,  16'h0000, 16'h1234, 1'b0, 3'd0);
    add(PUSH, 16'hAAAA, 16'hAAAA, 1'b0, 3'd1);
    add(PUSH, 16'hBBBB, 16'hBBBB, 1'b0, 3'd2);
    add(PEEK, 16'h0000, 16'hBBBB, 1'b0, 3'd2);
    add(POP,  16'h0000, 16'hBBBB, 1'b0, 3'd1);
    add(POP,  16'h0000, 16'hAAAA, 1'b0, 3'd0);
    add(POP,  16'h0000, 16'h0000, 1'b1, 3'd0);
    add(PEEK, 16'h0000, 16'h0000, 1'b1, 3'd0);
    add(REPL, 16'h0055, 16'h0000, 1'b1, 3'd0);
    for (int i = 1; i <= 7; i++) add(PUSH, 16'(i), 16'(i), 1'b0, 3'(i));
    add(PUSH, 16'h0008, 16'h0000, 1'b1, 3'd7);
    for (int i = 7; i >= 1; i--) add(POP, 16'h0000, 16'(i), 1'b0, 3'(i - 1));
    add(PUSH, 16'h0005, 16'h0005, 1'b0, 3'd1);
    add(REPL, 16'h00FF, 16'h00FF, 1'b0, 3'd1);
    add(PEEK, 16'h0000, 16'h00FF, 1'b0, 3'd1, 5);
    add(POP,  16'h0000, 16'h00FF, 1'b0, 3'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    foreach (vecs[i])
      do_cmd(vecs[i].op, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err,
             vecs[i].exp_depth, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset while the PUSH is on the stack bus: abort, no response, depth stays 0.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 16'h7777;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort.issue_we", 32'(stk_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort.no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("abort.depth", 32'(depth), 32'd0);

    // Random commands against a plain queue model of the stack.
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) op = PUSH;
      d  = 16'($urandom);
      ed = '0;
      ee = 1'b0;
      case (op)
        PUSH: if (model.size() == int'(CAP)) ee = 1'b1; else begin model.push_back(d); ed = d; end
        POP:  if (model.size() == 0) ee = 1'b1; else ed = model.pop_back();
        PEEK: if (model.size() == 0) ee = 1'b1; else ed = model[model.size() - 1];
        default: if (model.size() == 0) ee = 1'b1; else begin model[model.size() - 1] = d; ed = d; end
      endcase
      do_cmd(op, d, ed, ee, 3'(model.size()), int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
